// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : ALU operation codes, RV32I opcodes and the issue bundle type
//          shared by the issue stage and the ALU.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLT   = 4'd2;
    localparam logic [3:0] ALU_SLTU  = 4'd3;
    localparam logic [3:0] ALU_AND   = 4'd4;
    localparam logic [3:0] ALU_OR    = 4'd5;
    localparam logic [3:0] ALU_XOR   = 4'd6;
    localparam logic [3:0] ALU_LUI   = 4'd7;
    localparam logic [3:0] ALU_AUIPC = 4'd8;
    localparam logic [3:0] ALU_BEQ   = 4'd9;
    localparam logic [3:0] ALU_BNE   = 4'd10;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [3:0]      operation;
        logic [4:0]      rd;
        logic            wb_en;
        logic            illegal;
    } issue_t;

    localparam issue_t ISSUE_RESET = '{
        a:         '0,
        b:         '0,
        operation: ALU_ADD,
        rd:        5'd0,
        wb_en:     1'b0,
        illegal:   1'b0
    };

    function automatic logic [XLEN-1:0] imm_i(input logic [31:0] instr);
        return {{(XLEN-12){instr[31]}}, instr[31:20]};
    endfunction

    function automatic logic [XLEN-1:0] imm_u(input logic [31:0] instr);
        return {{(XLEN-20){1'b0}}, instr[31:12]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_issue_decode.sv
// ============================================================================
// Module : alu_issue_decode
// Brief  : Combinational decode of the ALU-relevant RV32I subset into an
//          issue bundle; anything outside the subset becomes an illegal bundle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_issue_decode
    import alu_pkg::*;
(
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic [XLEN-1:0] i_pc,
    output issue_t          o_issue
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic [4:0] w_rd;
    logic       w_f7_zero;
    logic [3:0] w_op;
    logic       w_legal;

    assign w_opcode  = i_instr[6:0];
    assign w_rd      = i_instr[11:7];
    assign w_funct3  = i_instr[14:12];
    assign w_funct7  = i_instr[31:25];
    assign w_f7_zero = (w_funct7 == 7'b0000000);

    always_comb begin
        w_op    = ALU_ADD;
        w_legal = 1'b0;
        o_issue = ISSUE_RESET;
        o_issue.illegal = 1'b1;

        case (w_opcode)
            OPC_OP: begin
                case (w_funct3)
                    3'b000: begin
                        if (w_f7_zero) begin
                            w_legal = 1'b1;
                            w_op    = ALU_ADD;
                        end else if (w_funct7 == 7'b0100000) begin
                            w_legal = 1'b1;
                            w_op    = ALU_SUB;
                        end
                    end
                    3'b010:  begin w_legal = w_f7_zero; w_op = ALU_SLT;  end
                    3'b011:  begin w_legal = w_f7_zero; w_op = ALU_SLTU; end
                    3'b100:  begin w_legal = w_f7_zero; w_op = ALU_XOR;  end
                    3'b110:  begin w_legal = w_f7_zero; w_op = ALU_OR;   end
                    3'b111:  begin w_legal = w_f7_zero; w_op = ALU_AND;  end
                    default: w_legal = 1'b0;
                endcase
                if (w_legal) begin
                    o_issue = '{a: i_rs1_data, b: i_rs2_data, operation: w_op,
                                rd: w_rd, wb_en: 1'b1, illegal: 1'b0};
                end
            end
            // Shift immediates (001/101) are deliberately left out of the subset
            OPC_OP_IMM: begin
                case (w_funct3)
                    3'b000:  begin w_legal = 1'b1; w_op = ALU_ADD;  end
                    3'b010:  begin w_legal = 1'b1; w_op = ALU_SLT;  end
                    3'b011:  begin w_legal = 1'b1; w_op = ALU_SLTU; end
                    3'b100:  begin w_legal = 1'b1; w_op = ALU_XOR;  end
                    3'b110:  begin w_legal = 1'b1; w_op = ALU_OR;   end
                    3'b111:  begin w_legal = 1'b1; w_op = ALU_AND;  end
                    default: w_legal = 1'b0;
                endcase
                if (w_legal) begin
                    o_issue = '{a: i_rs1_data, b: imm_i(i_instr), operation: w_op,
                                rd: w_rd, wb_en: 1'b1, illegal: 1'b0};
                end
            end
            OPC_LUI: begin
                o_issue = '{a: '0, b: imm_u(i_instr), operation: ALU_LUI,
                            rd: w_rd, wb_en: 1'b1, illegal: 1'b0};
            end
            OPC_AUIPC: begin
                o_issue = '{a: i_pc, b: imm_u(i_instr), operation: ALU_AUIPC,
                            rd: w_rd, wb_en: 1'b1, illegal: 1'b0};
            end
            OPC_BRANCH: begin
                if (w_funct3 == 3'b000 || w_funct3 == 3'b001) begin
                    o_issue = '{a: i_rs1_data, b: i_rs2_data,
                                operation: (w_funct3[0] ? ALU_BNE : ALU_BEQ),
                                rd: 5'd0, wb_en: 1'b0, illegal: 1'b0};
                end
            end
            default: o_issue.illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_issue_stage.sv
// ============================================================================
// Module : alu_issue_stage
// Brief  : Decode/issue register stage feeding the ALU, with a two-entry skid
//          buffer so IN_READY is independent of OUT_READY.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [31:0]     INSTR,
    input  logic [SIZE-1:0] RS1_DATA,
    input  logic [SIZE-1:0] RS2_DATA,
    input  logic [SIZE-1:0] PC,
    input  logic            FLUSH,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [SIZE-1:0] A,
    output logic [SIZE-1:0] B,
    output logic [3:0]      OPERATION,
    output logic [4:0]      RD,
    output logic            WB_EN,
    output logic            ILLEGAL
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t state_q, state_d;
    issue_t out_q,   out_d;
    issue_t skid_q,  skid_d;
    issue_t w_dec;
    logic   w_in_fire;
    logic   w_out_fire;

    alu_issue_decode u_decode (
        .i_instr    (INSTR),
        .i_rs1_data (RS1_DATA),
        .i_rs2_data (RS2_DATA),
        .i_pc       (PC),
        .o_issue    (w_dec)
    );

    assign IN_READY   = (state_q != ST_TWO) && RST_N;
    assign OUT_VALID  = (state_q != ST_EMPTY);
    assign w_in_fire  = IN_VALID && IN_READY;
    assign w_out_fire = OUT_VALID && OUT_READY;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (FLUSH) begin
            // A same-cycle IN_VALID is dropped even though IN_READY may be high
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        out_d   = w_dec;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        out_d = w_dec;
                    end else if (w_in_fire) begin
                        skid_d  = w_dec;
                        state_d = ST_TWO;
                    end else if (w_out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_out_fire) begin
                        out_d   = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_EMPTY;
            out_q   <= ISSUE_RESET;
            skid_q  <= ISSUE_RESET;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    assign A         = out_q.a;
    assign B         = out_q.b;
    assign OPERATION = out_q.operation;
    assign RD        = out_q.rd;
    assign WB_EN     = out_q.wb_en;
    assign ILLEGAL   = out_q.illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
// ============================================================================
// Module : tb_alu_issue_stage
// Brief  : Scoreboard bench for alu_issue_stage: expected bundles are queued
//          on acceptance and compared as they leave the stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_alu_issue_stage;
    import alu_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] INSTR;
    logic [31:0] RS1_DATA;
    logic [31:0] RS2_DATA;
    logic [31:0] PC;
    logic        FLUSH;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  OPERATION;
    logic [4:0]  RD;
    logic        WB_EN;
    logic        ILLEGAL;

    int     total = 0;
    int     bad   = 0;
    issue_t sb[$];
    issue_t e;

    always #5 CLK = ~CLK;

    alu_issue_stage #(.SIZE(32)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .INSTR     (INSTR),
        .RS1_DATA  (RS1_DATA),
        .RS2_DATA  (RS2_DATA),
        .PC        (PC),
        .FLUSH     (FLUSH),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .A         (A),
        .B         (B),
        .OPERATION (OPERATION),
        .RD        (RD),
        .WB_EN     (WB_EN),
        .ILLEGAL   (ILLEGAL)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic issue_t mk(input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] op, input logic [4:0] rd,
                                  input logic wb, input logic ill);
        mk = '{a: a, b: b, operation: op, rd: rd, wb_en: wb, illegal: ill};
    endfunction

    localparam issue_t BAD = '{a: '0, b: '0, operation: 4'd0, rd: 5'd0, wb_en: 1'b0, illegal: 1'b1};

    // Output monitor: every transfer must match the oldest expected bundle
    always @(negedge CLK) begin
        if (RST_N && OUT_VALID && OUT_READY) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("A",       A,                 e.a);
                chk("B",       B,                 e.b);
                chk("OP",      {28'd0, OPERATION}, {28'd0, e.operation});
                chk("RD",      {27'd0, RD},        {27'd0, e.rd});
                chk("WB_EN",   {31'd0, WB_EN},     {31'd0, e.wb_en});
                chk("ILLEGAL", {31'd0, ILLEGAL},   {31'd0, e.illegal});
            end
        end
    end

    // Entered and left at posedge+1
    task automatic send(input logic [31:0] ins, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] p, input issue_t exp);
        bit ok = 1'b0;
        IN_VALID = 1'b1;
        INSTR    = ins;
        RS1_DATA = r1;
        RS2_DATA = r2;
        PC       = p;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge CLK);
            if (IN_READY) ok = 1'b1;
        end
        if (ok) sb.push_back(exp);
        else    chk("in_ready_timeout", 32'd0, 32'd1);
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
    endtask

    task automatic drain();
        OUT_READY = 1'b1;
        for (int k = 0; k < 40 && sb.size() != 0; k++) @(posedge CLK);
        #1;
        chk("drain_left", sb.size(), 32'd0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ovalid"}, {31'd0, OUT_VALID}, 32'd0);
        chk({tag, "_A"},      A,                  32'd0);
        chk({tag, "_B"},      B,                  32'd0);
        chk({tag, "_op"},     {28'd0, OPERATION}, {28'd0, ALU_ADD});
        chk({tag, "_rd"},     {27'd0, RD},        32'd0);
        chk({tag, "_wb"},     {31'd0, WB_EN},     32'd0);
        chk({tag, "_ill"},    {31'd0, ILLEGAL},   32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST_N = 1'b0; IN_VALID = 1'b0; INSTR = '0; RS1_DATA = '0; RS2_DATA = '0;
        PC = '0; FLUSH = 1'b0; OUT_READY = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_in_ready", {31'd0, IN_READY}, 32'd0);
        chk_reset_outs("rst");
        @(posedge CLK); #1;
        RST_N = 1'b1;
        @(negedge CLK);
        chk("post_rst_in_ready", {31'd0, IN_READY}, 32'd1);
        @(posedge CLK); #1;

        // Streaming decode with the ALU always ready
        OUT_READY = 1'b1;
        send(32'h002081B3, 32'd5, 32'd7, 32'h100, mk(32'd5, 32'd7, ALU_ADD, 5'd3, 1'b1, 1'b0));
        send(32'hFFF00093, 32'd0, 32'd9, 32'h104, mk(32'd0, 32'hFFFFFFFF, ALU_ADD, 5'd1, 1'b1, 1'b0));
        send(32'h123452B7, 32'd3, 32'd4, 32'h108, mk(32'd0, 32'h00012345, ALU_LUI, 5'd5, 1'b1, 1'b0));
        send(32'h003110B3, 32'h55, 32'h66, 32'h10C, BAD);
        send(32'h00209063, 32'h11, 32'h22, 32'h110, mk(32'h11, 32'h22, ALU_BNE, 5'd0, 1'b0, 1'b0));
        send(32'h00208063, 32'h33, 32'h44, 32'h114, mk(32'h33, 32'h44, ALU_BEQ, 5'd0, 1'b0, 1'b0));
        send(32'h402081B3, 32'd9, 32'd2, 32'h118, mk(32'd9, 32'd2, ALU_SUB, 5'd3, 1'b1, 1'b0));
        send(32'h0020B333, 32'd1, 32'd2, 32'h11C, mk(32'd1, 32'd2, ALU_SLTU, 5'd6, 1'b1, 1'b0));
        send(32'h4020E1B3, 32'd1, 32'd2, 32'h120, BAD);
        send(32'h0F00F393, 32'hABC, 32'd0, 32'h124, mk(32'hABC, 32'h000000F0, ALU_AND, 5'd7, 1'b1, 1'b0));
        send(32'hABCDE217, 32'd7, 32'd8, 32'h2000, mk(32'h2000, 32'h000ABCDE, ALU_AUIPC, 5'd4, 1'b1, 1'b0));
        send(32'h0000A083, 32'd7, 32'd8, 32'h12C, BAD);
        drain();

        // Backpressure fills the skid, then releases in order
        OUT_READY = 1'b0;
        send(32'h0020C233, 32'hA1, 32'hB1, 32'h200, mk(32'hA1, 32'hB1, ALU_XOR, 5'd4, 1'b1, 1'b0));
        send(32'h0020E2B3, 32'hA2, 32'hB2, 32'h204, mk(32'hA2, 32'hB2, ALU_OR, 5'd5, 1'b1, 1'b0));
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("bp_in_ready", {31'd0, IN_READY}, 32'd0);
            chk("bp_ovalid",   {31'd0, OUT_VALID}, 32'd1);
            chk("bp_hold_A",   A, 32'hA1);
            chk("bp_hold_op",  {28'd0, OPERATION}, {28'd0, ALU_XOR});
        end
        @(posedge CLK); #1;
        OUT_READY = 1'b1;
        @(negedge CLK); #1;
        chk("bp_first_out", sb.size(), 32'd1);
        @(negedge CLK); #1;
        chk("bp_second_out", sb.size(), 32'd0);
        chk("bp_ready_again", {31'd0, IN_READY}, 32'd1);
        @(posedge CLK); #1;

        // Flush while full, with a new instruction offered the same cycle
        OUT_READY = 1'b0;
        send(32'h002081B3, 32'd1, 32'd1, 32'h300, mk(32'd1, 32'd1, ALU_ADD, 5'd3, 1'b1, 1'b0));
        send(32'h002081B3, 32'd2, 32'd2, 32'h304, mk(32'd2, 32'd2, ALU_ADD, 5'd3, 1'b1, 1'b0));
        FLUSH = 1'b1; IN_VALID = 1'b1; INSTR = 32'h00A00513; RS1_DATA = 32'd0;
        sb.delete();
        @(posedge CLK); #1;
        FLUSH = 1'b0; IN_VALID = 1'b0;
        @(negedge CLK);
        chk("flush2_ovalid",   {31'd0, OUT_VALID}, 32'd0);
        chk("flush2_in_ready", {31'd0, IN_READY},  32'd1);
        @(posedge CLK); #1;
        OUT_READY = 1'b1;
        repeat (4) @(posedge CLK);
        #1;

        // Flush from one entry while IN_READY is high
        OUT_READY = 1'b0;
        send(32'h002081B3, 32'd3, 32'd3, 32'h400, mk(32'd3, 32'd3, ALU_ADD, 5'd3, 1'b1, 1'b0));
        FLUSH = 1'b1; IN_VALID = 1'b1; INSTR = 32'h00A00513;
        sb.delete();
        @(posedge CLK); #1;
        FLUSH = 1'b0; IN_VALID = 1'b0;
        @(negedge CLK);
        chk("flush1_ovalid", {31'd0, OUT_VALID}, 32'd0);
        @(posedge CLK); #1;
        OUT_READY = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        send(32'h0010A113, 32'd8, 32'd0, 32'h500, mk(32'd8, 32'd1, ALU_SLT, 5'd2, 1'b1, 1'b0));
        drain();

        // Asynchronous reset while holding two entries
        OUT_READY = 1'b0;
        send(32'h002081B3, 32'd4, 32'd4, 32'h600, mk(32'd4, 32'd4, ALU_ADD, 5'd3, 1'b1, 1'b0));
        send(32'h002081B3, 32'd5, 32'd5, 32'h604, mk(32'd5, 32'd5, ALU_ADD, 5'd3, 1'b1, 1'b0));
        RST_N = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_ovalid",   {31'd0, OUT_VALID}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, IN_READY},  32'd0);
        @(negedge CLK);
        chk("mid_rst_in_ready_hold", {31'd0, IN_READY}, 32'd0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        @(negedge CLK);
        chk("mid_rst_release_ready", {31'd0, IN_READY}, 32'd1);
        chk_reset_outs("mid_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
